// File: rtl/stage_wb.sv
// stage_wb: write-back stage of the RVX pipeline, driving the ID-stage
// register-file write port.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   validIn          : retiring instruction from MEM this cycle
//   weIn, rdIn       : instruction writes rd / destination register
//   srcIn            : result source (0 ALU, 1 load, 2 pc+4, 3 as 0)
//   resIn, pcPlusIn  : ALU result, pc+4
//   ldFunct3In       : load funct3
//   ldAddrLoIn       : load address bits [1:0]
//   memRvalid        : load data valid
//   memRdata         : load data word
//   regAddrOut       : register-file write address (held between writes)
//   regWeOut         : register-file write enable, one-cycle pulse
//   regWDataOut      : register-file write data (held between writes)
//   stallOut         : combinational hold request to upstream stages
//   errOut           : sticky error (bad funct3 or load timeout)
module stage_wb #(
    parameter int BUS_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic             weIn,
    input  logic [4:0]       rdIn,
    input  logic [1:0]       srcIn,
    input  logic [BUS_W-1:0] resIn,
    input  logic [BUS_W-1:0] pcPlusIn,
    input  logic [2:0]       ldFunct3In,
    input  logic [1:0]       ldAddrLoIn,
    input  logic             memRvalid,
    input  logic [BUS_W-1:0] memRdata,
    output logic [4:0]       regAddrOut,
    output logic             regWeOut,
    output logic [BUS_W-1:0] regWDataOut,
    output logic             stallOut,
    output logic             errOut
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_d;

    logic [7:0] cnt, cnt_d;
    logic [8:0] cnt_inc;

    logic       we_q;
    logic [4:0] rd_q;
    logic [2:0] f3_q;
    logic [1:0] lo_q;

    logic [2:0] f3_s;
    logic [1:0] lo_s;

    logic [BUS_W-1:0] byte_sh;
    logic [BUS_W-1:0] half_sh;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [BUS_W-1:0] ext;
    logic             ext_bad;

    logic             wr;
    logic [4:0]       wr_rd;
    logic [BUS_W-1:0] wr_data;
    logic             set_err;
    logic             lat;

    // In WAIT the MEM inputs are stale, so extraction uses the latched fields.
    always_comb begin
        f3_s    = (state == WAIT) ? f3_q : ldFunct3In;
        lo_s    = (state == WAIT) ? lo_q : ldAddrLoIn;
        byte_sh = memRdata >> {lo_s, 3'b000};
        half_sh = memRdata >> {lo_s[1], 4'b0000};
        byte_v  = byte_sh[7:0];
        half_v  = half_sh[15:0];
        ext     = '0;
        ext_bad = 1'b0;
        case (f3_s)
            3'b000:  ext = {{(BUS_W-8){byte_v[7]}}, byte_v};
            3'b100:  ext = {{(BUS_W-8){1'b0}}, byte_v};
            3'b001:  ext = {{(BUS_W-16){half_v[15]}}, half_v};
            3'b101:  ext = {{(BUS_W-16){1'b0}}, half_v};
            3'b010:  ext = memRdata;
            default: ext_bad = 1'b1;
        endcase
    end

    assign cnt_inc = {1'b0, cnt} + 9'd1;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        wr       = 1'b0;
        wr_rd    = rdIn;
        wr_data  = resIn;
        set_err  = 1'b0;
        lat      = 1'b0;
        stallOut = 1'b0;
        case (state)
            IDLE: begin
                if (validIn) begin
                    if (srcIn != 2'd1) begin
                        wr = weIn && (rdIn != 5'd0);
                        if (srcIn == 2'd2) begin
                            wr_data = pcPlusIn;
                        end
                    end else if (memRvalid) begin
                        wr      = weIn && (rdIn != 5'd0);
                        wr_data = ext;
                        set_err = ext_bad;
                    end else begin
                        lat      = 1'b1;
                        cnt_d    = 8'd0;
                        state_d  = WAIT;
                        stallOut = 1'b1;
                    end
                end
            end
            WAIT: begin
                stallOut = !memRvalid;
                wr_rd    = rd_q;
                wr_data  = ext;
                if (memRvalid) begin
                    // Data arriving on the timeout cycle still wins.
                    wr      = we_q && (rd_q != 5'd0);
                    set_err = ext_bad;
                    state_d = IDLE;
                end else if (cnt_inc == 9'(TIMEOUT)) begin
                    set_err = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regAddrOut  <= 5'd0;
            regWeOut    <= 1'b0;
            regWDataOut <= '0;
            errOut      <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 5'd0;
            f3_q        <= 3'd0;
            lo_q        <= 2'd0;
        end else begin
            regWeOut <= wr;
            if (wr) begin
                regAddrOut  <= wr_rd;
                regWDataOut <= wr_data;
            end
            if (set_err) begin
                errOut <= 1'b1;
            end
            if (lat) begin
                we_q <= weIn;
                rd_q <= rdIn;
                f3_q <= ldFunct3In;
                lo_q <= ldAddrLoIn;
            end
        end
    end

endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: directed table-driven bench for stage_wb plus hand
// sequences for load wait, timeout, reset and bad funct3.
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        validIn;
    logic        weIn;
    logic [4:0]  rdIn;
    logic [1:0]  srcIn;
    logic [31:0] resIn;
    logic [31:0] pcPlusIn;
    logic [2:0]  ldFunct3In;
    logic [1:0]  ldAddrLoIn;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic [4:0]  regAddrOut;
    logic        regWeOut;
    logic [31:0] regWDataOut;
    logic        stallOut;
    logic        errOut;

    int n_tests = 0;
    int n_fail  = 0;

    stage_wb #(.BUS_W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .validIn    (validIn),
        .weIn       (weIn),
        .rdIn       (rdIn),
        .srcIn      (srcIn),
        .resIn      (resIn),
        .pcPlusIn   (pcPlusIn),
        .ldFunct3In (ldFunct3In),
        .ldAddrLoIn (ldAddrLoIn),
        .memRvalid  (memRvalid),
        .memRdata   (memRdata),
        .regAddrOut (regAddrOut),
        .regWeOut   (regWeOut),
        .regWDataOut(regWDataOut),
        .stallOut   (stallOut),
        .errOut     (errOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] pc;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string nm, input logic e_we,
                          input logic [4:0] e_rd, input logic [31:0] e_d);
        chk({nm, ".we"}, 32'(regWeOut), 32'(e_we));
        chk({nm, ".addr"}, 32'(regAddrOut), 32'(e_rd));
        chk({nm, ".data"}, regWDataOut, e_d);
    endtask

    task automatic load(input logic [2:0] f3, input logic we,
                        input logic [4:0] rd);
        validIn    = 1'b1;
        srcIn      = 2'd1;
        ldFunct3In = f3;
        ldAddrLoIn = 2'd0;
        weIn       = we;
        rdIn       = rd;
        memRvalid  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h1234_5678,
                     32'h200, 1'b1, 5'd5, 32'h1234_5678};
        vecs[1]  = '{2'd2, 3'd0, 2'd0, 1'b1, 5'd1, 32'hFFFF_0000,
                     32'h104, 1'b1, 5'd1, 32'h0000_0104};
        vecs[2]  = '{2'd3, 3'd0, 2'd0, 1'b1, 5'd4, 32'hA5A5_0000,
                     32'h200, 1'b1, 5'd4, 32'hA5A5_0000};
        vecs[3]  = '{2'd1, 3'd0, 2'd3, 1'b1, 5'd3, 32'h0,
                     32'h0, 1'b1, 5'd3, 32'hFFFF_FF80};
        vecs[4]  = '{2'd1, 3'd4, 2'd2, 1'b1, 5'd3, 32'h0,
                     32'h0, 1'b1, 5'd3, 32'h0000_00FF};
        vecs[5]  = '{2'd1, 3'd1, 2'd2, 1'b1, 5'd3, 32'h0,
                     32'h0, 1'b1, 5'd3, 32'hFFFF_80FF};
        vecs[6]  = '{2'd1, 3'd5, 2'd0, 1'b1, 5'd3, 32'h0,
                     32'h0, 1'b1, 5'd3, 32'h0000_7F01};
        vecs[7]  = '{2'd1, 3'd2, 2'd0, 1'b1, 5'd3, 32'h0,
                     32'h0, 1'b1, 5'd3, 32'h80FF_7F01};
        vecs[8]  = '{2'd0, 3'd0, 2'd0, 1'b1, 5'd0, 32'h0000_1111,
                     32'h0, 1'b0, 5'd3, 32'h80FF_7F01};
        vecs[9]  = '{2'd1, 3'd2, 2'd0, 1'b0, 5'd6, 32'h0,
                     32'h0, 1'b0, 5'd3, 32'h80FF_7F01};
        vecs[10] = '{2'd1, 3'd4, 2'd1, 1'b1, 5'd9, 32'h0,
                     32'h0, 1'b1, 5'd9, 32'h0000_007F};
        vecs[11] = '{2'd1, 3'd1, 2'd1, 1'b1, 5'd10, 32'h0,
                     32'h0, 1'b1, 5'd10, 32'h0000_7F01};

        rst        = 1'b1;
        validIn    = 1'b0;
        weIn       = 1'b0;
        rdIn       = 5'd0;
        srcIn      = 2'd0;
        resIn      = 32'h0;
        pcPlusIn   = 32'h0;
        ldFunct3In = 3'd0;
        ldAddrLoIn = 2'd0;
        memRvalid  = 1'b0;
        memRdata   = 32'h0;
        #2;
        chk_wr("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.err", 32'(errOut), 32'd0);
        chk("reset.stall", 32'(stallOut), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back single-cycle captures, one write per cycle.
        memRdata  = 32'h80FF_7F01;
        memRvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            validIn    = 1'b1;
            srcIn      = vecs[i].src;
            ldFunct3In = vecs[i].f3;
            ldAddrLoIn = vecs[i].lo;
            weIn       = vecs[i].we;
            rdIn       = vecs[i].rd;
            resIn      = vecs[i].res;
            pcPlusIn   = vecs[i].pc;
            #1;
            chk($sformatf("v%0d.stall", i), 32'(stallOut), 32'd0);
            tick();
            chk_wr($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_rd,
                   vecs[i].e_data);
        end
        validIn   = 1'b0;
        memRvalid = 1'b0;
        tick();
        chk("tbl.we_off", 32'(regWeOut), 32'd0);
        chk("tbl.err", 32'(errOut), 32'd0);

        // Delayed load, MEM inputs scrambled while waiting.
        load(3'd2, 1'b1, 5'd7);
        #1;
        chk("dly.stall0", 32'(stallOut), 32'd1);
        tick();
        srcIn      = 2'd0;
        rdIn       = 5'd12;
        resIn      = 32'h5555_AAAA;
        ldFunct3In = 3'd0;
        ldAddrLoIn = 2'd3;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk($sformatf("dly.stall%0d", k), 32'(stallOut), 32'd1);
            tick();
            chk($sformatf("dly.we%0d", k), 32'(regWeOut), 32'd0);
        end
        memRvalid = 1'b1;
        memRdata  = 32'hDEAD_BEEF;
        validIn   = 1'b0;
        #1;
        chk("dly.stall_data", 32'(stallOut), 32'd0);
        tick();
        chk_wr("dly.wr", 1'b1, 5'd7, 32'hDEAD_BEEF);
        memRvalid = 1'b0;
        tick();
        chk("dly.pulse", 32'(regWeOut), 32'd0);
        chk("dly.err", 32'(errOut), 32'd0);

        // Waiting load with weIn=0 never writes.
        load(3'd2, 1'b0, 5'd6);
        tick();
        validIn   = 1'b0;
        memRvalid = 1'b1;
        tick();
        chk("we0.we", 32'(regWeOut), 32'd0);
        chk("we0.err", 32'(errOut), 32'd0);
        memRvalid = 1'b0;
        tick();

        // Timeout with no data.
        load(3'd2, 1'b1, 5'd8);
        tick();
        validIn = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("to.err_early", 32'(errOut), 32'd0);
        chk("to.stall4", 32'(stallOut), 32'd1);
        tick();
        chk("to.err", 32'(errOut), 32'd1);
        chk("to.we", 32'(regWeOut), 32'd0);
        chk("to.stall_after", 32'(stallOut), 32'd0);
        validIn = 1'b1;
        srcIn   = 2'd0;
        weIn    = 1'b1;
        rdIn    = 5'd11;
        resIn   = 32'h0000_0055;
        tick();
        chk_wr("to.alu", 1'b1, 5'd11, 32'h0000_0055);
        validIn = 1'b0;

        // Asynchronous reset in WAIT discards the pending load.
        load(3'd2, 1'b1, 5'd13);
        tick();
        validIn = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk_wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.err", 32'(errOut), 32'd0);
        chk("rst.stall", 32'(stallOut), 32'd0);
        tick();
        rst       = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 32'h0000_0077;
        tick();
        chk("rst.stray1", 32'(regWeOut), 32'd0);
        tick();
        chk("rst.stray2", 32'(regWeOut), 32'd0);
        memRvalid = 1'b0;

        // Data on the TIMEOUT-th wait cycle wins.
        load(3'd2, 1'b1, 5'd14);
        tick();
        validIn = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        memRvalid = 1'b1;
        memRdata  = 32'hCAFE_0001;
        #1;
        chk("race.stall", 32'(stallOut), 32'd0);
        tick();
        chk_wr("race", 1'b1, 5'd14, 32'hCAFE_0001);
        chk("race.err", 32'(errOut), 32'd0);
        memRvalid = 1'b0;
        tick();

        // Reserved funct3 writes zero and flags an error.
        load(3'd3, 1'b1, 5'd2);
        memRvalid = 1'b1;
        memRdata  = 32'hFFFF_FFFF;
        tick();
        chk_wr("badf3", 1'b1, 5'd2, 32'h0);
        chk("badf3.err", 32'(errOut), 32'd1);
        validIn   = 1'b0;
        memRvalid = 1'b0;
        tick();
        chk("badf3.pulse", 32'(regWeOut), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_wb.md
# stage_wb

Write-back stage of the RVX pipeline: the write side of the ID-stage register file port. It accepts retiring instructions from the MEM stage and drives `regAddrOut` / `regWeOut` / `regWDataOut` into the ID stage's register-write inputs. It waits for variable-latency load data, holding the pipeline while waiting, and performs load byte/halfword extraction with sign/zero extension. It flags lost loads with a timeout.

## Interface
Parameters:
- `BUS_W`, 32: datapath width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before a load is abandoned; legal range 1..255.

Ports (reset is asynchronous, active-high):
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset.
- `validIn` in 1: a retiring instruction is presented this cycle.
- `weIn` in 1: the instruction writes `rd`.
- `rdIn` in 5: destination register.
- `srcIn` in 2: result source. 0 = ALU result, 1 = load, 2 = pc+4, 3 = reserved (treated as 0).
- `resIn` in BUS_W: ALU result.
- `pcPlusIn` in BUS_W: pc+4.
- `ldFunct3In` in 3: load funct3.
- `ldAddrLoIn` in 2: address bits [1:0] of the load.
- `memRvalid` in 1: load data valid.
- `memRdata` in BUS_W: load data word.
- `regAddrOut` out 5: register-file write address.
- `regWeOut` out 1: register-file write enable; one-cycle pulse.
- `regWDataOut` out BUS_W: register-file write data.
- `stallOut` out 1: combinational; the upstream pipeline must hold.
- `errOut` out 1: sticky error flag.

## Operation
- States: IDLE, WAIT.
- **IDLE, `validIn`=0:** no write. `memRvalid` is ignored.
- **IDLE, `validIn`=1, `srcIn`≠1:** capture the result. Data is `resIn` for `srcIn` 0 or 3, and `pcPlusIn` for `srcIn` 2. Write next cycle.
- **IDLE, `validIn`=1, `srcIn`=1, `memRvalid`=1:** extract from `memRdata` and write next cycle. Stay in IDLE.
- **IDLE, `validIn`=1, `srcIn`=1, `memRvalid`=0:** latch `weIn`, `rdIn`, `ldFunct3In`, `ldAddrLoIn`. Clear the counter and go to WAIT.
- **WAIT:** `validIn` and the other MEM inputs are ignored; upstream is held. On `memRvalid`, extract using the latched fields, write next cycle, and go to IDLE.
- **Timeout:** the counter increments each WAIT cycle without `memRvalid`. When the count reaches `TIMEOUT`, set `errOut`, drop the load (no write), and go to IDLE. If `memRvalid` arrives in that same cycle, the data wins: write, and no error.
- **Write gating:** `regWeOut` pulses only if the captured `weIn`=1 and `rd`≠0. `rd`=0 never asserts `regWeOut`.
- **Load extraction:**
  - Byte lane = `ldAddrLoIn`.
  - Half lane = `ldAddrLoIn[1]`; bit 0 is ignored.
  - funct3 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half. 101 LHU: zero-extend half.
  - 010 LW: full word.
  - 011, 110, 111: data 0, and set `errOut` in the same capture cycle.
- **Output hold:** `regAddrOut` and `regWDataOut` hold their last value while `regWeOut`=0.
- **`stallOut`** = (state==WAIT) OR (IDLE AND `validIn` AND `srcIn`==1 AND !`memRvalid`). It is deasserted in the cycle `memRvalid` is seen in WAIT.

## Timing
- **Reset values:** `regAddrOut`=0, `regWeOut`=0, `regWDataOut`=0, `errOut`=0, state IDLE, counter 0. `stallOut` evaluates to 0 unless IDLE input conditions assert it.
- **Reset mid-WAIT:** the pending load is discarded. A later `memRvalid` with `validIn`=0 causes no write.
- **Latency:**
  - Capture at edge N gives `regWeOut`=1 during cycle N+1, for exactly one cycle.
  - Load with data at cycle M gives the write in cycle M+1.
- **Throughput:** back-to-back non-load instructions produce one write per cycle with no bubble.
- **Timeout:** with no data, `errOut` rises at the edge ending the `TIMEOUT`-th WAIT cycle. `stallOut` is deasserted from the next cycle.
- **`errOut`:** cleared only by `rst`.

## Test plan
- **ALU then pc+4:**
  - Cycle 0: `validIn`=1, `srcIn`=0, `rdIn`=5, `resIn`=0x1234_5678. Cycle 1: `srcIn`=2, `rdIn`=1, `pcPlusIn`=0x104.
  - Required: cycle 1 writes (5, 0x1234_5678); cycle 2 writes (1, 0x104); `stallOut`=0 throughout.
- **Same-cycle load, `memRvalid`=1, `memRdata`=0x80FF_7F01, rd=3:**
  - LB at lo=3 → 0xFFFF_FF80.
  - LBU at lo=2 → 0x0000_00FF.
  - LH at lo=2 → 0xFFFF_80FF.
  - LHU at lo=0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- **Delayed load:**
  - Stimulus: LW rd=7, with `memRvalid` arriving 4 cycles later carrying 0xDEAD_BEEF.
  - Required: `stallOut`=1 for 4 cycles and 0 in the data cycle; next cycle writes (7, 0xDEAD_BEEF); MEM inputs changed during WAIT have no effect.
- **rd=0 / `weIn`=0:** ALU with rd=0, and a load with `weIn`=0 → `regWeOut` stays 0; `errOut` stays 0.
- **Timeout (`TIMEOUT`=4):**
  - Load with no `memRvalid` → `errOut`=1 after 4 WAIT cycles; no write; state IDLE. A following ALU instruction writes normally.
  - Repeat with `memRvalid` on the 4th cycle → write occurs, `errOut`=0.
- **Reset / invalid funct3:**
  - Assert `rst` during WAIT → all outputs 0 immediately (asynchronous); a subsequent stray `memRvalid` causes no write.
  - funct3=011, rd=2 → write (2, 0) and `errOut`=1.
